// File: rtl/reg_seq_pkg.sv
// Shared encodings for the register command sequencer.
// Ctrl codes are shared with the downstream parallel register.
package reg_seq_pkg;

  localparam logic [1:0] CTRL_NONE = 2'd0;
  localparam logic [1:0] CTRL_LOAD = 2'd1;
  localparam logic [1:0] CTRL_INCR = 2'd2;
  localparam logic [1:0] CTRL_CLR  = 2'd3;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_INCR = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/reg_cmd_skid_buffer.sv
// One-entry command holding register (op + arg + valid flag).
// Used by reg_cmd_sequencer only when REG_SEQ_CMD_SKID_EN is defined.
module reg_cmd_skid_buffer
  import reg_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             i_push,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_arg,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [1:0]       o_op,
  output logic [WIDTH-1:0] o_arg
);

  logic             r_valid;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_arg;

  // Capture on push, release on pop; reset empties the entry.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_valid <= 1'b0;
      r_op    <= OP_NOP;
      r_arg   <= '0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_op    <= i_op;
      r_arg   <= i_arg;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_op    = r_op;
  assign o_arg   = r_arg;

endmodule

// File: rtl/reg_cmd_sequencer.sv
// Expands valid/ready commands into per-cycle ctrl codes for the parallel
// register. INCR by N becomes N cycles of CTRL_INCR (N=0 acts as NOP).
// Optional REG_SEQ_CMD_SKID_EN adds a one-entry command buffer so a
// command accepted during EXEC starts right after done, with no IDLE gap.
module reg_cmd_sequencer
  import reg_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic [1:0]       reg_ctrl,
  output logic [WIDTH-1:0] reg_data,
  output logic             busy,
  output logic             done
);

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [1:0]           r_ctrl;
  logic [WIDTH-1:0]     r_data;
  logic                 r_busy, r_done;

  logic                 w_acc, w_last, w_start;
  logic [1:0]           w_sop;
  logic [WIDTH-1:0]     w_sarg;
  logic [CNT_WIDTH-1:0] w_n, w_scnt;
  logic [1:0]           w_sctrl;

  // r_cnt holds the cycles remaining including the one being driven now.
  assign w_last = (r_state == ST_EXEC) && (r_cnt == CNT_WIDTH'(1));

`ifdef REG_SEQ_CMD_SKID_EN
  logic             w_buf_vld, w_push, w_pop;
  logic [1:0]       w_buf_op;
  logic [WIDTH-1:0] w_buf_arg;

  assign cmd_ready = !sync_reset &&
                     ((r_state == ST_IDLE) || ((r_state == ST_EXEC) && !w_buf_vld));
  assign w_acc   = cmd_valid && cmd_ready;
  // A buffered command has priority at the final cycle; an empty buffer lets a
  // command arriving on the final cycle bypass straight into EXEC.
  assign w_pop   = w_last && w_buf_vld;
  assign w_push  = w_acc && (r_state == ST_EXEC) && !w_last;
  assign w_start = (w_acc && !w_push) || w_pop;
  assign w_sop   = w_pop ? w_buf_op  : cmd_op;
  assign w_sarg  = w_pop ? w_buf_arg : cmd_arg;

  reg_cmd_skid_buffer #(.WIDTH(WIDTH)) u_skid (
    .clk        (clk),
    .sync_reset (sync_reset),
    .i_push     (w_push),
    .i_op       (cmd_op),
    .i_arg      (cmd_arg),
    .i_pop      (w_pop),
    .o_valid    (w_buf_vld),
    .o_op       (w_buf_op),
    .o_arg      (w_buf_arg)
  );
`else
  assign cmd_ready = !sync_reset && (r_state == ST_IDLE);
  assign w_acc     = cmd_valid && cmd_ready;
  assign w_start   = w_acc;
  assign w_sop     = cmd_op;
  assign w_sarg    = cmd_arg;
`endif

  // Decode the starting command into its first ctrl code and cycle count.
  always_comb begin
    w_n     = w_sarg[CNT_WIDTH-1:0];
    w_sctrl = CTRL_NONE;
    w_scnt  = CNT_WIDTH'(1);
    case (w_sop)
      OP_LOAD: w_sctrl = CTRL_LOAD;
      OP_CLR:  w_sctrl = CTRL_CLR;
      OP_INCR: begin
        if (w_n != '0) begin
          w_sctrl = CTRL_INCR;
          w_scnt  = w_n;
        end
      end
      default: w_sctrl = CTRL_NONE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (sync_reset) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state: leave EXEC after the last cycle unless another command starts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_EXEC;
      ST_EXEC: if (w_last && !w_start) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs and repeat counter.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_cnt  <= '0;
      r_ctrl <= CTRL_NONE;
      r_data <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (w_start) begin
      r_cnt  <= w_scnt;
      r_ctrl <= w_sctrl;
      if (w_sop == OP_LOAD) r_data <= w_sarg;
      r_busy <= 1'b1;
      r_done <= (w_scnt == CNT_WIDTH'(1));
    end else if (r_state == ST_EXEC) begin
      if (w_last) begin
        r_cnt  <= '0;
        r_ctrl <= CTRL_NONE;
        r_busy <= 1'b0;
        r_done <= 1'b0;
      end else begin
        r_cnt  <= r_cnt - CNT_WIDTH'(1);
        r_done <= (r_cnt == CNT_WIDTH'(2));
      end
    end
  end

  assign reg_ctrl = r_ctrl;
  assign reg_data = r_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
